// File: rtl/regfile_mp_if.sv
// Interface bundling the regfile_mp clear, read, write and issue signals.
// master: decode/writeback side (drives requests, sees read results)
// slave : register file side
//   clear_req, init_done           - clear-sweep control and status
//   rd_en, rd_addr, rd_data,       - NRP packed read ports, port i at
//   rd_busy, stall                   [i*AW +: AW] / [i*XLEN +: XLEN]
//   wa_*, wb_*                     - write ports A and B (B has priority)
//   issue_valid, issue_rd          - destination register of an issuing op
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRP  = 3
);
  logic                 clear_req;
  logic                 init_done;
  logic [NRP-1:0]       rd_en;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP-1:0]       rd_busy;
  logic                 stall;
  logic                 wa_en;
  logic [AW-1:0]        wa_addr;
  logic [XLEN-1:0]      wa_data;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;

  modport master (
    output clear_req, rd_en, rd_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, issue_valid, issue_rd,
    input  init_done, rd_data, rd_busy, stall
  );

  modport slave (
    input  clear_req, rd_en, rd_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, issue_valid, issue_rd,
    output init_done, rd_data, rd_busy, stall
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// busy scoreboard for hazard stalls, and a sequential clear sweep that zeroes
// every register after reset or on clear_req.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (restarts the clear sweep)
//   bus   - regfile_mp_if.slave: clear/status, NRP read ports, write ports
//           A and B, issue destination
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRP     = 3,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [NREGS-1:0]     busy_q, busy_d;
  logic [XLEN-1:0]      regs_q [NREGS];

  logic                 ready;
  logic                 commit;
  logic                 we_a, we_b;
  logic [NRP-1:0][XLEN-1:0] rd_data_c;
  logic [NRP-1:0]       rd_busy_c;

  assign ready  = (state_q == ST_READY);
  // A clear request in READY drops any write on the same edge.
  assign commit = ready && !bus.clear_req;
  assign we_a   = commit && bus.wa_en && !(ZERO_R0 && (bus.wa_addr == '0));
  assign we_b   = commit && bus.wb_en && !(ZERO_R0 && (bus.wb_addr == '0));

  // Next-state logic for the clear sweep / ready FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == AW'(NREGS - 1)) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_READY: begin
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard: writes retire a producer, an issue on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (bus.clear_req) begin
        busy_d = '0;
      end else begin
        if (we_a) busy_d[bus.wa_addr] = 1'b0;
        if (we_b) busy_d[bus.wb_addr] = 1'b0;
        if (bus.issue_valid) busy_d[bus.issue_rd] = 1'b1;
        if (ZERO_R0) busy_d[0] = 1'b0;
      end
    end
  end

  // Read ports with bypass; a same-cycle write also resolves the hazard.
  always_comb begin
    logic [AW-1:0] addr;
    logic          hit_a;
    logic          hit_b;
    rd_data_c = '0;
    rd_busy_c = '0;
    addr      = '0;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    for (int i = 0; i < int'(NRP); i++) begin
      addr  = bus.rd_addr[i*AW +: AW];
      hit_a = bus.wa_en && (bus.wa_addr == addr);
      hit_b = bus.wb_en && (bus.wb_addr == addr);
      if (ready && bus.rd_en[i]) begin
        if (ZERO_R0 && (addr == '0)) begin
          rd_data_c[i] = '0;
        end else if (hit_b) begin
          rd_data_c[i] = bus.wb_data;
        end else if (hit_a) begin
          rd_data_c[i] = bus.wa_data;
        end else begin
          rd_data_c[i] = regs_q[addr];
        end
        rd_busy_c[i] = busy_q[addr] && !hit_a && !hit_b;
      end
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.stall     = |rd_busy_c;
  assign bus.init_done = ready;

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Register storage; contents are initialised by the sweep, not by reset.
  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else begin
      if (we_a) regs_q[bus.wa_addr] <= bus.wa_data;
      if (we_b) regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRP   = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) bus ();

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRP(NRP), .ZERO_R0(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_reg  [NREGS];
  bit          m_busy [NREGS];
  bit          m_ready;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
      foreach (m_busy[r]) m_busy[r] <= 1'b0;
    end else if (!m_ready) begin
      m_reg[m_cnt] <= 32'h0;
      if (m_cnt == int'(NREGS) - 1) begin
        m_cnt   <= 0;
        m_ready <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus.clear_req) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
      foreach (m_busy[r]) m_busy[r] <= 1'b0;
    end else begin
      if (bus.wa_en && bus.wa_addr != 0) begin
        m_reg[bus.wa_addr]  <= bus.wa_data;
        m_busy[bus.wa_addr] <= 1'b0;
      end
      if (bus.wb_en && bus.wb_addr != 0) begin
        m_reg[bus.wb_addr]  <= bus.wb_data;
        m_busy[bus.wb_addr] <= 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input int i);
    logic [4:0] a;
    a = bus.rd_addr[i*5 +: 5];
    if (!m_ready || !bus.rd_en[i]) return 32'h0;
    if (a == 0) return 32'h0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int i);
    logic [4:0] a;
    a = bus.rd_addr[i*5 +: 5];
    if (!m_ready || !bus.rd_en[i]) return 1'b0;
    if (bus.wb_en && bus.wb_addr == a) return 1'b0;
    if (bus.wa_en && bus.wa_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.clear_req   = 1'b0;
    bus.rd_en       = '0;
    bus.rd_addr     = '0;
    bus.wa_en       = 1'b0;
    bus.wa_addr     = '0;
    bus.wa_data     = '0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read0(input logic [4:0] a);
    bus.rd_en   = 3'b001;
    bus.rd_addr = '0;
    bus.rd_addr[4:0] = a;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.init_done !== 1'b0) begin
      bad++; $display("FAIL reset_init_done got=%b exp=0", bus.init_done);
    end
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    total++;
    if (n != 32) begin
      bad++; $display("FAIL reset_sweep_cycles got=%0d exp=32", n);
    end
    for (int a = 0; a < 32; a++) begin
      bus.rd_en = 3'b111;
      for (int p = 0; p < 3; p++) bus.rd_addr[p*5 +: 5] = 5'((a + p) % 32);
      #1;
      total++;
      if (bus.rd_data !== 96'h0) begin
        bad++; $display("FAIL reset_zero_read addr=%0d got=%h exp=0", a, bus.rd_data);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEADBEEF;
    read0(5'd5);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", bus.rd_data[31:0]);
    end
    tick();
    idle();
    read0(5'd5);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_next_cycle got=%h exp=deadbeef", bus.rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_dual_write();
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11111111;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h22222222;
    read0(5'd7);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'h22222222) begin
      bad++; $display("FAIL dual_write_bypass got=%h exp=22222222", bus.rd_data[31:0]);
    end
    tick();
    idle();
    read0(5'd7);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'h22222222) begin
      bad++; $display("FAIL dual_write_stored got=%h exp=22222222", bus.rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_r0();
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFFFFFF;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    read0(5'd0);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      bad++; $display("FAIL r0_same_cycle got=%h exp=0", bus.rd_data[31:0]);
    end
    tick();
    idle();
    read0(5'd0);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      bad++; $display("FAIL r0_next_cycle got=%h exp=0", bus.rd_data[31:0]);
    end
    total++;
    if (bus.rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL r0_busy got=%b exp=0", bus.rd_busy[0]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle();
    read0(5'd9);
    @(negedge clk);
    total++;
    if (bus.rd_busy[0] !== 1'b1 || bus.stall !== 1'b1) begin
      bad++; $display("FAIL sb_hazard got busy=%b stall=%b exp busy=1 stall=1",
                      bus.rd_busy[0], bus.stall);
    end
    bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h5;
    #1;
    total++;
    if (bus.rd_busy[0] !== 1'b0 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL sb_bypass_resolve got busy=%b stall=%b exp 0 0",
                      bus.rd_busy[0], bus.stall);
    end
    total++;
    if (bus.rd_data[31:0] !== 32'h5) begin
      bad++; $display("FAIL sb_bypass_data got=%h exp=5", bus.rd_data[31:0]);
    end
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h6;
    tick();
    idle();
    read0(5'd9);
    @(negedge clk);
    total++;
    if (bus.rd_busy[0] !== 1'b1) begin
      bad++; $display("FAIL sb_set_wins got=%b exp=1", bus.rd_busy[0]);
    end
    total++;
    if (bus.rd_data[31:0] !== 32'h6) begin
      bad++; $display("FAIL sb_set_wins_data got=%h exp=6", bus.rd_data[31:0]);
    end
    tick();
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h7;
    tick();
    idle();
  endtask

  task automatic test_clear();
    idle();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'hA5;
    tick();
    idle();
    read0(5'd3);
    @(negedge clk);
    total++;
    if (bus.rd_data[31:0] !== 32'hA5) begin
      bad++; $display("FAIL clear_pre_value got=%h exp=a5", bus.rd_data[31:0]);
    end
    tick();
    bus.clear_req = 1'b1;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd4; bus.wa_data = 32'h77;
    tick();
    for (int k = 0; k < 32; k++) begin
      bus.clear_req = 1'b0;
      bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'hFF;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hEE;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      bus.rd_en = 3'b111; bus.rd_addr = {5'd4, 5'd3, 5'd3};
      @(negedge clk);
      total++;
      if (bus.init_done !== 1'b0 || bus.rd_data !== 96'h0 || bus.stall !== 1'b0) begin
        bad++; $display("FAIL clear_sweep_outputs cycle=%0d got init=%b data=%h stall=%b exp 0 0 0",
                        k, bus.init_done, bus.rd_data, bus.stall);
      end
      tick();
    end
    idle();
    bus.rd_en = 3'b011; bus.rd_addr = {5'd0, 5'd4, 5'd3};
    #1;
    total++;
    if (bus.init_done !== 1'b1) begin
      bad++; $display("FAIL clear_done got=%b exp=1", bus.init_done);
    end
    total++;
    if (bus.rd_data[63:0] !== 64'h0 || bus.rd_busy !== 3'b000) begin
      bad++; $display("FAIL clear_result got data=%h busy=%b exp 0 000",
                      bus.rd_data[63:0], bus.rd_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle();
    bus.clear_req = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.init_done !== 1'b0) begin
      bad++; $display("FAIL midreset_init got=%b exp=0", bus.init_done);
    end
    tick();
    rst_n = 1'b1;
    wait_init(n);
    total++;
    if (n != 32) begin
      bad++; $display("FAIL midreset_sweep_cycles got=%0d exp=32", n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.clear_req = ($urandom_range(0, 79) == 0);
      bus.rd_en     = 3'($urandom);
      for (int p = 0; p < 3; p++) bus.rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
      bus.wa_en     = 1'($urandom);
      bus.wa_addr   = 5'($urandom_range(0, 7));
      bus.wa_data   = $urandom;
      bus.wb_en     = 1'($urandom);
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.issue_valid = 1'($urandom);
      bus.issue_rd  = 5'($urandom_range(0, 7));
      @(negedge clk);
      total++;
      if (bus.init_done !== m_ready) begin
        bad++; $display("FAIL rand_init cycle=%0d got=%b exp=%b", c, bus.init_done, m_ready);
      end
      for (int p = 0; p < 3; p++) begin
        total++;
        if (bus.rd_data[p*32 +: 32] !== exp_rd(p)) begin
          bad++; $display("FAIL rand_data cycle=%0d port=%0d got=%h exp=%h",
                          c, p, bus.rd_data[p*32 +: 32], exp_rd(p));
        end
        total++;
        if (bus.rd_busy[p] !== exp_busy(p)) begin
          bad++; $display("FAIL rand_busy cycle=%0d port=%0d got=%b exp=%b",
                          c, p, bus.rd_busy[p], exp_busy(p));
        end
      end
      total++;
      if (bus.stall !== (exp_busy(0) | exp_busy(1) | exp_busy(2))) begin
        bad++; $display("FAIL rand_stall cycle=%0d got=%b", c, bus.stall);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_dual_write();
    test_r0();
    test_scoreboard();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the pipeline integer register file.
- Provides NRP combinational read ports, two write ports with fixed priority, and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for hazard stall generation.
- Adds a sequential clear engine that zeroes every register after reset or on request.
- Sits between decode (reads, issue) and writeback (writes) in the pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- AW, 5, address width, equal to log2(NREGS).
- NRP, 3, number of read ports.
- ZERO_R0, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear_req, input, 1, single-cycle pulse that starts a clear sweep.
- init_done, output, 1, high when the file is usable.
- rd_en, input, NRP, per-port read enable.
- rd_addr, input, NRP*AW, packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data, output, NRP*XLEN, packed read data.
- rd_busy, output, NRP, per-port scoreboard hit.
- stall, output, 1, OR of rd_busy over enabled ports.
- wa_en, input, 1, write port A enable.
- wa_addr, input, AW, write port A address.
- wa_data, input, XLEN, write port A data.
- wb_en, input, 1, write port B enable (higher priority than A).
- wb_addr, input, AW, write port B address.
- wb_data, input, XLEN, write port B data.
- issue_valid, input, 1, an instruction with destination issue_rd is issuing.
- issue_rd, input, AW, destination of the issuing instruction.

Behaviour:
- Reset (rst_n low): FSM goes to CLEAR; clear counter = 0; all busy bits = 0; init_done = 0. Register contents are not reset directly; the sweep zeroes them.
- FSM states: CLEAR and READY.
- CLEAR:
  - Writes register[cnt] = 0 each cycle and increments cnt.
  - At cnt == NREGS-1, the zero write happens, cnt wraps to 0, and the FSM goes to READY.
  - The sweep takes exactly NREGS cycles.
  - During CLEAR: init_done = 0, wa/wb/issue are ignored, rd_data = 0, rd_busy = 0, stall = 0, clear_req is ignored.
- READY:
  - init_done = 1.
  - clear_req = 1 moves the FSM to CLEAR next cycle. Busy bits clear on that same edge, and any write on that edge is dropped.
- Reset asserted mid-sweep restarts the sweep from register 0.
- Writes, READY only:
  - Committed at posedge.
  - If wa_addr == wb_addr with both enabled, B's data is stored.
  - With ZERO_R0=1, writes to address 0 are discarded.
- Reads, combinational:
  - Disabled port: rd_data = 0 (no tristate).
  - Enabled port, priority order:
    1. Address 0 with ZERO_R0=1 gives 0.
    2. wb_en and address match gives wb_data.
    3. wa_en and address match gives wa_data.
    4. Otherwise the stored register value.
  - Written data is visible without bypass from the next cycle.
- Scoreboard, READY only:
  - busy[r] sets at posedge when issue_valid && issue_rd == r (r != 0 if ZERO_R0).
  - busy[r] clears at posedge when either write port writes r.
  - If issue and write to the same r coincide, set wins: the result is busy = 1, the new producer is pending, and the data is still written.
- rd_busy and stall:
  - rd_busy[i] = rd_en[i] && busy[addr_i] && no same-cycle write to addr_i. A bypass hit resolves the hazard.
  - stall = |rd_busy.
- Outputs never carry X after reset, because registers are swept before init_done rises.

Test Plan:
- Release rst_n; count cycles until init_done rises -> exactly 32 cycles (defaults). Reading addresses 0..31 then returns 0x00000000.
- Write A to x5 = 0xDEADBEEF while port 0 reads x5 in the same cycle -> rd_data0 = 0xDEADBEEF via bypass. The next cycle, with no write, also reads 0xDEADBEEF.
- wa and wb both write x7 (A = 0x11111111, B = 0x22222222) -> same-cycle read and next-cycle read both give 0x22222222.
- Write x0 = 0xFFFFFFFF, issue_rd = 0 -> x0 reads 0 and rd_busy stays 0.
- Issue x9; next cycle read x9 -> rd_busy = 1 and stall = 1. Write x9 = 0x5 that cycle -> rd_busy = 0 and data = 0x5. Issue x9 and write x9 in the same cycle -> busy remains 1.
- clear_req in READY after writing x3 = 0xA5 -> init_done = 0 for 32 cycles, writes are ignored, x3 then reads 0. Assert rst_n low at sweep cycle 10 -> the sweep restarts and takes 32 cycles from release.
